// File: rtl/tile_drain.sv
// tile_drain: reads an NxN tile of W-bit elements from the register file one
// row per cycle, buffers it, then streams the rows (optionally transposed)
// to the writeback path over a valid/ready handshake.
module tile_drain #(
  parameter int N      = 4,
  parameter int W      = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           sel,
  input  logic                 transpose,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           rf_sel_out,
  output logic                 rf_rd,
  output logic [$clog2(N)-1:0] rf_row,
  input  logic [N*W-1:0]       rf_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*W-1:0]       out_data,
  output logic [$clog2(N)-1:0] out_row
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND} state_t;

  state_t          r_state;
  logic            r_tr;
  logic [N*W-1:0]  r_buf [N];
  logic            r_tag_v [RD_LAT];
  logic [RW-1:0]   r_tag_row [RD_LAT];

  logic            w_cap;
  logic [RW-1:0]   w_cap_row;
  logic [N*W-1:0]  w_buf_next [N];
  logic [RW-1:0]   w_next_idx;
  logic [N*W-1:0]  w_plain;
  logic [N*W-1:0]  w_trans;
  logic [N*W-1:0]  w_next_data;

  // The oldest tag marks the row whose data is on rf_data this cycle.
  assign w_cap     = r_tag_v[RD_LAT-1];
  assign w_cap_row = r_tag_row[RD_LAT-1];

  // Buffer contents as they will be after this edge; lets the first output
  // row be formed in the same cycle the last tile row lands.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_buf_next
      assign w_buf_next[gi] = (w_cap && (w_cap_row == RW'(gi))) ? rf_data : r_buf[gi];
    end
  endgenerate

  // Row index of the next row to present: 0 when entering SEND, i+1 after a handshake.
  assign w_next_idx = (r_state == S_SEND) ? (out_row + RW'(1)) : '0;

  // Form the next output row, plain or transposed.
  always_comb begin
    w_plain = w_buf_next[w_next_idx];
    w_trans = '0;
    for (int k = 0; k < N; k++) begin
      w_trans[k*W +: W] = w_buf_next[k][W*int'(w_next_idx) +: W];
    end
    w_next_data = r_tr ? w_trans : w_plain;
  end

  // Delay line tagging each read strobe with its row until its data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_row[i] <= '0;
      end
    end else begin
      r_tag_v[0]   <= rf_rd;
      r_tag_row[0] <= rf_row;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
      end
    end
  end

  // Tile buffer: capture each returning row into its slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) r_buf[r] <= '0;
    end else begin
      for (int r = 0; r < N; r++) r_buf[r] <= w_buf_next[r];
    end
  end

  // Control FSM with registered outputs: IDLE -> READ -> SEND -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tr       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rf_sel_out <= '0;
      rf_rd      <= 1'b0;
      rf_row     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_READ;
            r_tr       <= transpose;
            rf_sel_out <= sel;
            busy       <= 1'b1;
            rf_rd      <= 1'b1;
            rf_row     <= '0;
          end
        end
        S_READ: begin
          if (rf_rd) begin
            if (rf_row == LAST) begin
              rf_rd  <= 1'b0;
              rf_row <= '0;
            end else begin
              rf_row <= rf_row + RW'(1);
            end
          end
          if (w_cap && (w_cap_row == LAST)) begin
            r_state   <= S_SEND;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_data  <= w_next_data;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (out_row == LAST) begin
              r_state    <= S_IDLE;
              out_valid  <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              rf_sel_out <= '0;
            end else begin
              out_row  <= out_row + RW'(1);
              out_data <= w_next_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_drain.sv
// Directed bench for tile_drain: one RD_LAT=1 instance covers the main
// scenarios, a second RD_LAT=3 instance covers the read-latency parameter.
module tb_tile_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sel = '0;
  logic        transpose = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, rf_rd, out_valid;
  logic [3:0]  rf_sel_out;
  logic [1:0]  rf_row, out_row;
  logic [63:0] rf_data, out_data;

  logic        start3 = 1'b0;
  logic        busy3, done3, rf_rd3, out_valid3;
  logic [3:0]  rf_sel_out3;
  logic [1:0]  rf_row3, out_row3;
  logic [63:0] rf_data3, out_data3;

  logic [63:0] mem [16][4];
  logic [63:0] pipe1;
  logic [63:0] pipe3 [3];
  logic [63:0] exp_plain [4];
  logic [63:0] exp_tr [4];
  logic [63:0] exp_r2 [4];

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  always #5 clk = ~clk;

  tile_drain #(.N(4), .W(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .transpose(transpose),
    .busy(busy), .done(done), .rf_sel_out(rf_sel_out), .rf_rd(rf_rd),
    .rf_row(rf_row), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
  );

  tile_drain #(.N(4), .W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .sel(4'd1), .transpose(1'b0),
    .busy(busy3), .done(done3), .rf_sel_out(rf_sel_out3), .rf_rd(rf_rd3),
    .rf_row(rf_row3), .rf_data(rf_data3), .out_valid(out_valid3),
    .out_ready(1'b1), .out_data(out_data3), .out_row(out_row3)
  );

  // Regfile models with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    pipe1    <= rf_rd ? mem[rf_sel_out][rf_row] : BAD;
    pipe3[0] <= rf_rd3 ? mem[rf_sel_out3][rf_row3] : BAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rf_data  = pipe1;
  assign rf_data3 = pipe3[2];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_rd !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b rd=%b valid=%b want all 0", busy, done, rf_rd, out_valid);
    end
    checks++;
    if (rf_sel_out !== 4'd0 || rf_row !== 2'd0 || out_row !== 2'd0 || out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got sel=%0d row=%0d orow=%0d data=%h want 0", rf_sel_out, rf_row, out_row, out_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic exp_rd, exp_v, exp_busy;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b0; out_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_rd   = (k >= 1 && k <= 4);
      exp_v    = (k >= 6 && k <= 9);
      exp_busy = (k <= 9);
      checks++;
      if (rf_rd !== exp_rd || (exp_rd && (rf_row !== 2'(k-1) || rf_sel_out !== 4'd1))) begin
        errors++;
        $display("FAIL basic_read k=%0d got rd=%b row=%0d sel=%0d want rd=%b row=%0d sel=1", k, rf_rd, rf_row, rf_sel_out, exp_rd, k-1);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL basic_busy k=%0d got %b want %b", k, busy, exp_busy);
      end
      checks++;
      if (out_valid !== exp_v || (exp_v && (out_row !== 2'(k-6) || out_data !== exp_plain[k-6]))) begin
        errors++;
        $display("FAIL basic_out k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid, out_row, out_data, exp_v, k-6);
      end
      if (exp_v) $display("basic row %0d data %h", out_row, out_data);
      checks++;
      if (done !== (k == 10)) begin
        errors++;
        $display("FAIL basic_done k=%0d got %b want %b", k, done, k == 10);
      end
    end
  endtask

  task automatic test_transpose();
    logic exp_v;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b1; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0; transpose = 1'b0;
      exp_v = (k >= 6 && k <= 9);
      checks++;
      if (out_valid !== exp_v || (exp_v && (out_row !== 2'(k-6) || out_data !== exp_tr[k-6]))) begin
        errors++;
        $display("FAIL transpose_out k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid, out_row, out_data, exp_v, k-6);
      end
      if (exp_v) $display("transpose row %0d data %h", out_row, out_data);
      checks++;
      if (done !== (k == 10)) begin
        errors++;
        $display("FAIL transpose_done k=%0d got %b want %b", k, done, k == 10);
      end
    end
  endtask

  task automatic test_backpressure();
    logic exp_v;
    int   er;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b0; out_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = (k >= 6 && k <= 14);
      er = (k == 6) ? 0 : (k <= 10) ? 1 : (k == 11) ? 2 : 3;
      checks++;
      if (out_valid !== exp_v || (exp_v && (out_row !== 2'(er) || out_data !== exp_plain[er]))) begin
        errors++;
        $display("FAIL stall_out k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid, out_row, out_data, exp_v, er);
      end
      checks++;
      if (done !== (k == 15)) begin
        errors++;
        $display("FAIL stall_done k=%0d got %b want %b", k, done, k == 15);
      end
      out_ready = !(k == 7 || k == 8 || k == 9 || k == 12 || k == 13);
      if (exp_v) $display("stall k=%0d row %0d ready %b", k, out_row, out_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_sel;
    logic       exp_rd, exp_v, exp_busy;
    int         er;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b0; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_sel  = (k <= 9) ? 4'd1 : (k == 10 || k >= 20) ? 4'd0 : 4'd2;
      exp_busy = (k <= 9) || (k >= 11 && k <= 19);
      exp_rd   = (k >= 1 && k <= 4) || (k >= 11 && k <= 14);
      er       = (k <= 4) ? k - 1 : k - 11;
      checks++;
      if (rf_sel_out !== exp_sel || busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_sel k=%0d got sel=%0d busy=%b want sel=%0d busy=%b", k, rf_sel_out, busy, exp_sel, exp_busy);
      end
      checks++;
      if (rf_rd !== exp_rd || (exp_rd && rf_row !== 2'(er))) begin
        errors++;
        $display("FAIL b2b_read k=%0d got rd=%b row=%0d want rd=%b row=%0d", k, rf_rd, rf_row, exp_rd, er);
      end
      exp_v = (k >= 6 && k <= 9) || (k >= 16 && k <= 19);
      er    = (k <= 9) ? k - 6 : k - 16;
      checks++;
      if (out_valid !== exp_v ||
          (exp_v && (out_row !== 2'(er) || out_data !== ((k <= 9) ? exp_plain[er] : exp_r2[er])))) begin
        errors++;
        $display("FAIL b2b_out k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid, out_row, out_data, exp_v, er);
      end
      if (exp_v) $display("b2b k=%0d row %0d data %h", k, out_row, out_data);
      checks++;
      if (done !== (k == 10 || k == 20)) begin
        errors++;
        $display("FAIL b2b_done k=%0d got %b want %b", k, done, (k == 10 || k == 20));
      end
      if (k == 2) begin start = 1'b1; sel = 4'd5; transpose = 1'b1; end
      if (k == 7) begin start = 1'b1; sel = 4'd7; transpose = 1'b1; end
      if (k == 10) begin start = 1'b1; sel = 4'd2; transpose = 1'b0; end
    end
    transpose = 1'b0;
  endtask

  task automatic test_async_reset();
    logic exp_v;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b0; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1 || out_row !== 2'd2) begin
      errors++;
      $display("FAIL areset_pre got v=%b row=%0d want v=1 row=2", out_valid, out_row);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rf_rd !== 1'b0 || out_data !== 64'd0 || rf_sel_out !== 4'd0) begin
      errors++;
      $display("FAIL areset_async got v=%b busy=%b rd=%b data=%h sel=%0d want 0", out_valid, busy, rf_rd, out_data, rf_sel_out);
    end
    $display("async reset applied mid-send");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || rf_rd !== 1'b0) begin
        errors++;
        $display("FAIL areset_hold got done=%b rd=%b want 0", done, rf_rd);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    sel = 4'd1; transpose = 1'b1; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0; transpose = 1'b0;
      exp_v = (k >= 6 && k <= 9);
      checks++;
      if (out_valid !== exp_v || (exp_v && (out_row !== 2'(k-6) || out_data !== exp_tr[k-6]))) begin
        errors++;
        $display("FAIL areset_redrain k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid, out_row, out_data, exp_v, k-6);
      end
      checks++;
      if (done !== (k == 10)) begin
        errors++;
        $display("FAIL areset_done k=%0d got %b want %b", k, done, k == 10);
      end
    end
  endtask

  task automatic test_latency();
    logic exp_rd, exp_v;
    @(negedge clk);
    start3 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      exp_rd = (k >= 1 && k <= 4);
      exp_v  = (k >= 8 && k <= 11);
      checks++;
      if (rf_rd3 !== exp_rd || (exp_rd && rf_row3 !== 2'(k-1))) begin
        errors++;
        $display("FAIL lat3_read k=%0d got rd=%b row=%0d want rd=%b row=%0d", k, rf_rd3, rf_row3, exp_rd, k-1);
      end
      checks++;
      if (out_valid3 !== exp_v || (exp_v && (out_row3 !== 2'(k-8) || out_data3 !== exp_plain[k-8]))) begin
        errors++;
        $display("FAIL lat3_out k=%0d got v=%b row=%0d data=%h want v=%b row=%0d", k, out_valid3, out_row3, out_data3, exp_v, k-8);
      end
      if (exp_v) $display("lat3 row %0d data %h", out_row3, out_data3);
      checks++;
      if (done3 !== (k == 12)) begin
        errors++;
        $display("FAIL lat3_done k=%0d got %b want %b", k, done3, k == 12);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++)
        mem[s][r] = 64'hEEEE_0000_0000_0000 + 64'(s * 16 + r);
    exp_plain[0] = 64'h000D_0009_0005_0001;
    exp_plain[1] = 64'h000E_000A_0006_0002;
    exp_plain[2] = 64'h000F_000B_0007_0003;
    exp_plain[3] = 64'h0010_000C_0008_0004;
    exp_tr[0]    = 64'h0004_0003_0002_0001;
    exp_tr[1]    = 64'h0008_0007_0006_0005;
    exp_tr[2]    = 64'h000C_000B_000A_0009;
    exp_tr[3]    = 64'h0010_000F_000E_000D;
    exp_r2[0]    = 64'h2003_2002_2001_2000;
    exp_r2[1]    = 64'h2013_2012_2011_2010;
    exp_r2[2]    = 64'h2023_2022_2021_2020;
    exp_r2[3]    = 64'h2033_2032_2031_2030;
    for (int r = 0; r < 4; r++) begin
      mem[1][r] = exp_plain[r];
      mem[2][r] = exp_r2[r];
    end

    test_reset();
    test_basic();
    test_transpose();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_latency();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
